// File: rtl/beep_pkg.sv
// Shared widths, FSM state type and musical note periods for the buzzer scheduler.
package beep_pkg;

    localparam int PERIOD_W = 17;
    localparam int DUR_W    = 8;
    localparam int REP_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned CLK_PRE_DEF = 50_000_000;

    function automatic logic [PERIOD_W-1:0] note_period(input int unsigned clk_hz,
                                                        input int unsigned tone_hz);
        return PERIOD_W'(clk_hz / tone_hz);
    endfunction

    // Any period of 0 or 1 is treated as a rest by the scheduler.
    localparam logic [PERIOD_W-1:0] REST = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] DO   = note_period(CLK_PRE_DEF, 523);
    localparam logic [PERIOD_W-1:0] RE   = note_period(CLK_PRE_DEF, 587);
    localparam logic [PERIOD_W-1:0] MI   = note_period(CLK_PRE_DEF, 659);
    localparam logic [PERIOD_W-1:0] FA   = note_period(CLK_PRE_DEF, 698);
    localparam logic [PERIOD_W-1:0] SOL  = note_period(CLK_PRE_DEF, 784);
    localparam logic [PERIOD_W-1:0] LA   = note_period(CLK_PRE_DEF, 880);
    localparam logic [PERIOD_W-1:0] SI   = note_period(CLK_PRE_DEF, 988);

endpackage

// File: rtl/beep_sched_if.sv
// Requester-side job bus: one valid/ready pair plus a packed payload per requester.
interface beep_sched_if #(
    parameter int unsigned NREQ = 3
);
    import beep_pkg::*;

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*PERIOD_W-1:0] req_period;
    logic [NREQ*DUR_W-1:0]    req_on;
    logic [NREQ*DUR_W-1:0]    req_off;
    logic [NREQ*REP_W-1:0]    req_reps;

    modport master (
        output req_valid, req_period, req_on, req_off, req_reps,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_period, req_on, req_off, req_reps,
        output req_ready
    );

endinterface

// File: rtl/beep_tick.sv
// Duration prescaler: strobes tick for one cycle every TICK_CYC clocks, restartable by clr.
module beep_tick #(
    parameter int unsigned TICK_CYC = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     W    = $clog2(TICK_CYC);
    localparam logic [W-1:0]    LAST = W'(TICK_CYC - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/beep_sched.sv
// Fixed-priority, non-preemptive scheduler that plays on/off beep jobs on a shared tone generator.
module beep_sched
    import beep_pkg::*;
#(
    parameter int unsigned CLK_PRE  = 50_000_000,
    parameter int unsigned TICK_CYC = 50_000,
    parameter int unsigned NREQ     = 3
) (
    input  logic                clk,
    input  logic                rst,
    beep_sched_if.slave         req,
    input  logic                abort,
    output logic                tone_en,
    output logic [PERIOD_W-1:0] tone_period,
    output logic                busy,
    output logic [2:0]          grant_id,
    output logic [NREQ-1:0]     done
);

    if (NREQ < 2 || NREQ > 8 || TICK_CYC < 2 || CLK_PRE < TICK_CYC) begin : g_bad_cfg
        $error("beep_sched: illegal parameter combination");
    end

    function automatic logic [2:0] pick_lowest(input logic [NREQ-1:0] v);
        logic [2:0] g;
        g = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (v[i]) g = 3'(i);
        end
        return g;
    endfunction

    state_t              state;
    logic [PERIOD_W-1:0] job_period;
    logic [DUR_W-1:0]    job_on;
    logic [DUR_W-1:0]    job_off;
    logic [DUR_W-1:0]    phase_cnt;
    logic [REP_W-1:0]    rep_cnt;

    logic [2:0]          pick;
    logic [NREQ-1:0]     ready_d;
    logic                take;
    logic                tick;
    logic                tick_clr;
    logic [PERIOD_W-1:0] sel_period;
    logic [DUR_W-1:0]    sel_on;
    logic [DUR_W-1:0]    sel_off;
    logic [REP_W-1:0]    sel_reps;

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        pick       = pick_lowest(req.req_valid);
        sel_period = req.req_period[pick*PERIOD_W +: PERIOD_W];
        sel_on     = req.req_on[pick*DUR_W +: DUR_W];
        sel_off    = req.req_off[pick*DUR_W +: DUR_W];
        sel_reps   = req.req_reps[pick*REP_W +: REP_W];
        if (sel_on == '0)   sel_on   = DUR_W'(1);
        if (sel_reps == '0) sel_reps = REP_W'(1);
        ready_d = '0;
        if (state == IDLE && !abort && (|req.req_valid)) begin
            ready_d = NREQ'(1) << pick;
        end
    end

    assign req.req_ready = ready_d;
    assign take          = |(req.req_valid & ready_d);
    assign tick_clr      = (state == IDLE) || (state == DONE);

    beep_tick #(
        .TICK_CYC (TICK_CYC)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            job_period  <= '0;
            job_on      <= '0;
            job_off     <= '0;
            phase_cnt   <= '0;
            rep_cnt     <= '0;
            tone_en     <= 1'b0;
            tone_period <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            done        <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (take) begin
                        job_period  <= sel_period;
                        job_on      <= sel_on;
                        job_off     <= sel_off;
                        phase_cnt   <= sel_on;
                        rep_cnt     <= sel_reps;
                        grant_id    <= pick;
                        tone_period <= sel_period;
                        tone_en     <= (sel_period > REST);
                        busy        <= 1'b1;
                        state       <= ON;
                    end
                end
                ON: begin
                    if (abort) begin
                        state   <= DONE;
                        tone_en <= 1'b0;
                        done    <= NREQ'(1) << grant_id;
                    end else if (tick) begin
                        if (phase_cnt == DUR_W'(1)) begin
                            rep_cnt <= rep_cnt - 1'b1;
                            if (rep_cnt == REP_W'(1)) begin
                                // Last repetition: no trailing gap.
                                state   <= DONE;
                                tone_en <= 1'b0;
                                done    <= NREQ'(1) << grant_id;
                            end else if (job_off == '0) begin
                                phase_cnt <= job_on;
                            end else begin
                                state     <= OFF;
                                phase_cnt <= job_off;
                                tone_en   <= 1'b0;
                            end
                        end else begin
                            phase_cnt <= phase_cnt - 1'b1;
                        end
                    end
                end
                OFF: begin
                    if (abort) begin
                        state <= DONE;
                        done  <= NREQ'(1) << grant_id;
                    end else if (tick) begin
                        if (phase_cnt == DUR_W'(1)) begin
                            state     <= ON;
                            phase_cnt <= job_on;
                            tone_en   <= (job_period > REST);
                        end else begin
                            phase_cnt <= phase_cnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    tone_period <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beep_sched.sv
// Self-checking bench for beep_sched with TICK_CYC=4; expected waveforms come from a job timeline model.
module tb_beep_sched;

    localparam int T    = 4;
    localparam int DO_P = 50_000_000 / 523;
    localparam int RE_P = 50_000_000 / 587;
    localparam int MI_P = 50_000_000 / 659;
    localparam int FA_P = 50_000_000 / 698;
    localparam int SO_P = 50_000_000 / 784;
    localparam int LA_P = 50_000_000 / 880;

    typedef struct packed {
        logic [2:0]  ready;
        logic        busy;
        logic        en;
        logic [16:0] per;
        logic [2:0]  done;
        logic [2:0]  gid;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        abort;
    logic        tone_en;
    logic [16:0] tone_period;
    logic        busy;
    logic [2:0]  grant_id;
    logic [2:0]  done;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t exp_q[$];
    obs_t got;

    beep_sched_if #(.NREQ(3)) bus();

    beep_sched #(
        .CLK_PRE  (50_000_000),
        .TICK_CYC (T),
        .NREQ     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (bus),
        .abort       (abort),
        .tone_en     (tone_en),
        .tone_period (tone_period),
        .busy        (busy),
        .grant_id    (grant_id),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t sample();
        return '{bus.req_ready, busy, tone_en, tone_period, done, grant_id};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("rdy=%b busy=%b en=%b per=%0d done=%b gid=%0d",
                         o.ready, o.busy, o.en, o.per, o.done, o.gid);
    endfunction

    // Timeline of a job from the cycle after acceptance: phases, then DONE, then one IDLE cycle.
    function automatic void build_exp(input int per, input int on, input int off, input int reps,
                                      input int id, input int abort_at, input logic [2:0] idle_ready);
        int n_on  = (on == 0) ? 1 : on;
        int n_rep = (reps == 0) ? 1 : reps;
        exp_q.delete();
        for (int r = 0; r < n_rep; r++) begin
            for (int c = 0; c < n_on * T; c++)
                exp_q.push_back('{3'b000, 1'b1, per > 1, 17'(per), 3'b000, 3'(id)});
            if (r < n_rep - 1)
                for (int c = 0; c < off * T; c++)
                    exp_q.push_back('{3'b000, 1'b1, 1'b0, 17'(per), 3'b000, 3'(id)});
        end
        if (abort_at >= 0)
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
        exp_q.push_back('{3'b000, 1'b1, 1'b0, 17'(per), 3'(1 << id), 3'(id)});
        exp_q.push_back('{idle_ready, 1'b0, 1'b0, 17'd0, 3'b000, 3'(id)});
    endfunction

    task automatic load_req(input int id, input int per, input int on, input int off, input int reps);
        bus.req_period[id*17 +: 17] = 17'(per);
        bus.req_on[id*8 +: 8]       = 8'(on);
        bus.req_off[id*8 +: 8]      = 8'(off);
        bus.req_reps[id*4 +: 4]     = 4'(reps);
        bus.req_valid[id]           = 1'b1;
    endtask

    task automatic start_job(input int id, input int per, input int on, input int off, input int reps);
        @(negedge clk);
        load_req(id, per, on, off, reps);
        @(posedge clk);
        #1 bus.req_valid[id] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        got = sample();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_bad++;
            $display("FAIL reset_hold: got %s want all zero", fmt(got));
        end
        rst = 1'b0;
        @(negedge clk);
        got = sample();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_bad++;
            $display("FAIL reset_idle: got %s want all zero", fmt(got));
        end
    endtask

    task automatic test_basic();
        start_job(0, DO_P, 3, 2, 2);
        build_exp(DO_P, 3, 2, 2, 0, -1, 3'b000);
        foreach (exp_q[k]) begin
            @(negedge clk);
            got = sample();
            n_cmp++;
            if (got !== exp_q[k]) begin
                n_bad++;
                $display("FAIL basic[%0d]: got %s want %s", k, fmt(got), fmt(exp_q[k]));
            end
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        load_req(1, MI_P, 1, 1, 2);
        load_req(2, FA_P, 2, 0, 2);
        #1;
        n_cmp++;
        if (bus.req_ready !== 3'b010) begin
            n_bad++;
            $display("FAIL prio_ready: got %b want 010", bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid[1] = 1'b0;
        build_exp(MI_P, 1, 1, 2, 1, -1, 3'b100);
        foreach (exp_q[k]) begin
            @(negedge clk);
            got = sample();
            n_cmp++;
            if (got !== exp_q[k]) begin
                n_bad++;
                $display("FAIL prio_job1[%0d]: got %s want %s", k, fmt(got), fmt(exp_q[k]));
            end
        end
        @(posedge clk);
        #1 bus.req_valid[2] = 1'b0;
        build_exp(FA_P, 2, 0, 2, 2, -1, 3'b000);
        foreach (exp_q[k]) begin
            @(negedge clk);
            got = sample();
            n_cmp++;
            if (got !== exp_q[k]) begin
                n_bad++;
                $display("FAIL prio_job2[%0d]: got %s want %s", k, fmt(got), fmt(exp_q[k]));
            end
        end
    endtask

    task automatic test_no_preempt();
        start_job(2, MI_P, 2, 1, 2);
        build_exp(MI_P, 2, 1, 2, 2, -1, 3'b001);
        foreach (exp_q[k]) begin
            @(negedge clk);
            got = sample();
            n_cmp++;
            if (got !== exp_q[k]) begin
                n_bad++;
                $display("FAIL nopre_job2[%0d]: got %s want %s", k, fmt(got), fmt(exp_q[k]));
            end
            if (k == 10) load_req(0, SO_P, 1, 0, 1);
        end
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        build_exp(SO_P, 1, 0, 1, 0, -1, 3'b000);
        foreach (exp_q[k]) begin
            @(negedge clk);
            got = sample();
            n_cmp++;
            if (got !== exp_q[k]) begin
                n_bad++;
                $display("FAIL nopre_job0[%0d]: got %s want %s", k, fmt(got), fmt(exp_q[k]));
            end
        end
    endtask

    task automatic test_rest();
        start_job(1, 1, 2, 0, 1);
        build_exp(1, 2, 0, 1, 1, -1, 3'b000);
        foreach (exp_q[k]) begin
            @(negedge clk);
            got = sample();
            n_cmp++;
            if (got !== exp_q[k]) begin
                n_bad++;
                $display("FAIL rest[%0d]: got %s want %s", k, fmt(got), fmt(exp_q[k]));
            end
        end
    endtask

    task automatic test_abort();
        start_job(0, RE_P, 3, 1, 2);
        build_exp(RE_P, 3, 1, 2, 0, 1, 3'b000);
        foreach (exp_q[k]) begin
            @(negedge clk);
            abort = 1'b0;
            got = sample();
            n_cmp++;
            if (got !== exp_q[k]) begin
                n_bad++;
                $display("FAIL abort_job[%0d]: got %s want %s", k, fmt(got), fmt(exp_q[k]));
            end
            if (k == 1) abort = 1'b1;
        end
        // Abort together with a valid request while idle must block acceptance.
        @(negedge clk);
        abort = 1'b1;
        load_req(1, LA_P, 1, 0, 1);
        #1;
        n_cmp++;
        if (bus.req_ready !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_idle_ready: got %b want 000", bus.req_ready);
        end
        @(posedge clk);
        #1;
        abort = 1'b0;
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 3'b000 || tone_en !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle_accept: got busy=%b done=%b en=%b want 0 000 0", busy, done, tone_en);
        end
    endtask

    task automatic test_normalise_reset();
        start_job(2, SO_P, 0, 0, 0);
        build_exp(SO_P, 0, 0, 0, 2, -1, 3'b000);
        foreach (exp_q[k]) begin
            @(negedge clk);
            got = sample();
            n_cmp++;
            if (got !== exp_q[k]) begin
                n_bad++;
                $display("FAIL norm[%0d]: got %s want %s", k, fmt(got), fmt(exp_q[k]));
            end
        end
        start_job(0, LA_P, 3, 0, 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        got = sample();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_bad++;
            $display("FAIL midjob_reset: got %s want all zero", fmt(got));
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 3'b000 || busy !== 1'b0 || tone_en !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_quiet[%0d]: got done=%b busy=%b en=%b want 000 0 0", c, done, busy, tone_en);
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 12; j++) begin
            int id   = $urandom_range(0, 2);
            int per  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 131071);
            int on   = $urandom_range(0, 3);
            int off  = $urandom_range(0, 2);
            int reps = $urandom_range(0, 3);
            int ab   = -1;
            build_exp(per, on, off, reps, id, -1, 3'b000);
            if ($urandom_range(0, 2) == 0) ab = $urandom_range(0, exp_q.size() - 3);
            build_exp(per, on, off, reps, id, ab, 3'b000);
            start_job(id, per, on, off, reps);
            foreach (exp_q[k]) begin
                @(negedge clk);
                abort = 1'b0;
                got = sample();
                n_cmp++;
                if (got !== exp_q[k]) begin
                    n_bad++;
                    $display("FAIL rand%0d[%0d]: got %s want %s", j, k, fmt(got), fmt(exp_q[k]));
                end
                if (k == ab) abort = 1'b1;
            end
        end
    endtask

    initial begin : main
        rst            = 1'b1;
        abort          = 1'b0;
        bus.req_valid  = '0;
        bus.req_period = '0;
        bus.req_on     = '0;
        bus.req_off    = '0;
        bus.req_reps   = '0;
        test_reset();
        test_basic();
        test_priority();
        test_no_preempt();
        test_rest();
        test_abort();
        test_normalise_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/beep_sched.md
# beep_sched

Fixed-priority scheduler that shares one buzzer tone generator between several requesters. Each requester submits a beep job over a valid/ready handshake. A job is a tone period, an on time, an off time and a repeat count. The block runs the on/off sequence and drives the tone generator's period and enable inputs. It sits between system event sources (key click, alarm, melody sequencer) and the square-wave buzzer datapath.

## Interface
- `CLK_PRE`, 50_000_000, system clock frequency in Hz; used only for the note constants.
- `TICK_CYC`, 50_000, clock cycles per duration tick (1 ms at 50 MHz); must be ≥ 2.
- `NREQ`, 3, number of requesters; legal range 2..8.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NREQ  job offered by requester i.
- `req_ready`  out  NREQ  job i accepted this cycle.
- `req_period`  in  NREQ*17  tone period in clocks, slice i = [17i+16:17i]; value ≤ 1 means rest.
- `req_on`  in  NREQ*8  on-phase length in ticks.
- `req_off`  in  NREQ*8  off-phase length in ticks.
- `req_reps`  in  NREQ*4  number of on phases.
- `abort`  in  1  terminate the running job.
- `tone_en`  out  1  tone generator enable; 1 = sound.
- `tone_period`  out  17  period presented to the tone generator.
- `busy`  out  1  a job is in progress (state ≠ IDLE).
- `grant_id`  out  3  index of the current or last granted requester.
- `done`  out  NREQ  one-cycle completion pulse for requester i.

## Operation
- States:
  - IDLE: no job.
  - ON: tone phase.
  - OFF: silent gap.
  - DONE: one cycle, completion.
- Arbitration (IDLE only):
  - g = lowest index with `req_valid` set.
  - `req_ready` = one-hot(g) combinationally, gated by `abort`=0.
  - Transfer occurs on the edge where valid&ready are both 1.
  - At transfer, latch period/on/off/reps into job registers, set `grant_id`=g, clear the prescaler, load the phase counter, go to ON.
- Operand normalisation at latch:
  - on=0 becomes 1.
  - reps=0 becomes 1.
  - off=0 means no OFF phase; ON phases run back to back.
- Job sequencing:
  - ON lasts on×TICK_CYC cycles.
  - At the end of ON, the repetition counter decrements.
  - If reps remain: go to OFF, or directly back to ON if off=0.
  - After the last ON, go to DONE. No trailing OFF.
  - OFF lasts off×TICK_CYC cycles, then returns to ON.
- Outputs:
  - `tone_en` = 1 only in ON with latched period > 1.
  - `tone_period` = latched period while busy, otherwise 0.
- DONE:
  - `done[grant_id]`=1 for exactly one cycle, `tone_en`=0, `busy`=1.
  - Next state is IDLE.
- Non-preemptive: a higher-priority valid during a job waits until IDLE.
- Abort in ON or OFF:
  - The next state is DONE, and the normal done pulse is generated.
  - `tone_en` falls on the next cycle.
- Abort in IDLE or DONE is ignored, except that it blocks acceptance in IDLE that cycle.
- Requesters hold the payload stable while valid is high. Dropping valid before ready is permitted: no job, no error.
- Arithmetic: the prescaler is $clog2(TICK_CYC) bits and wraps at TICK_CYC-1. The phase counter is 8 bits, counts down ticks and reloads from the latched on/off. The repetition counter is 4 bits.

## Timing
- Reset values:
  - state IDLE.
  - `tone_en` 0, `tone_period` 0, `busy` 0, `grant_id` 0, `done` 0.
  - all counters 0.
- Reset mid-job: silent the next cycle, job discarded, no done pulse.
- Latency: transfer edge E → `busy`=1 and `tone_en`=1 from cycle E+1.
- Job length in cycles = (reps·on + (reps−1)·off)·TICK_CYC, plus 1 DONE cycle.
- Back-to-back jobs: DONE, then at least one IDLE cycle, then acceptance. Minimum gap between jobs is 2 cycles of silence.
- `req_ready` is high only in IDLE, for at most one requester.

## Structure
- `beep_pkg` holds:
  - width constants PERIOD_W=17, DUR_W=8, REP_W=4.
  - state enum IDLE/ON/OFF/DONE.
  - note period constants DO..SI = CLK_PRE/{523,587,659,698,784,880,988}.
  - REST=1.
- Sub-module `beep_tick`: a TICK_CYC prescaler with synchronous clear that emits a one-cycle tick strobe.
- The priority pick is a function inside `beep_sched`.

## Test plan
All scenarios run with TICK_CYC=4.
- Req0 job with period=DO, on=3, off=2, reps=2 → `tone_en` high 12 cycles, low 8, high 12, then `done[0]` for 1 cycle; `busy` high for 33 cycles.
- `req_valid[1]` and `req_valid[2]` raised in the same cycle → `req_ready`=3'b010. Req2 is accepted only after `done[1]` plus one IDLE cycle; `grant_id` goes 1 then 2.
- Req0 valid raised mid-way through a req2 job → no preemption; req0 accepted in the first IDLE cycle after `done[2]`.
- Period=1 (REST), on=2, reps=1 → `tone_en` stays 0 for all 8 cycles, and `done` pulses on schedule.
- Abort raised in the 2nd cycle of ON → `tone_en` 0 the next cycle, DONE, `done` pulse, IDLE. Abort and valid together in IDLE → `req_ready`=0, no acceptance.
- on=0, reps=0 → `tone_en` high exactly 4 cycles. Then a new job with `rst` pulsed mid-ON → all outputs at reset values the next cycle, and no `done`.
